// File: rtl/simon_pkg.sv
// Shared definitions for the Simon pattern playback sequencer.
// Build option: SIMON_SEQ_BLANK_EN adds a one-cycle BLANK state between patterns.
package simon_pkg;

    localparam int unsigned MEM_DEPTH = 64;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned PAT_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        SHOW
`ifdef SIMON_SEQ_BLANK_EN
        ,
        BLANK
`endif
    } state_t;

endpackage

// File: rtl/simon_dwell_timer.sv
// Down-counter timing how long one pattern stays on the LEDs.
// Loaded with (cycles - 1); zero marks the final cycle of the dwell.
module simon_dwell_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load takes priority over decrement; counter saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/simon_playback_seq.sv
// Simon pattern playback sequencer: walks a synchronous-read pattern memory,
// showing each entry for a programmable dwell, once or looping.
// Build option: SIMON_SEQ_BLANK_EN inserts a BLANK cycle (LEDs off) between patterns.
module simon_playback_seq
    import simon_pkg::*;
#(
    parameter int unsigned DWELL_W = 16,
    parameter int unsigned PAT_W   = simon_pkg::PAT_W,
    parameter int unsigned ADDR_W  = simon_pkg::ADDR_W
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W:0]   seq_cnt,
    input  logic [DWELL_W-1:0] dwell,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [PAT_W-1:0]  mem_rdata,
    output logic [PAT_W-1:0]  pattern_leds,
    output logic [ADDR_W-1:0] cur_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   last_idx;
    logic                loop_q;
    logic [DWELL_W-1:0]  dwell_q;
    logic [DWELL_W-1:0]  dwell_load;
    logic [ADDR_W:0]     cnt_clamp;
    logic                tmr_zero;

    // Clamp requested length to the memory depth; dwell of 0 behaves as 1.
    always_comb begin
        cnt_clamp  = (seq_cnt > DEPTH) ? DEPTH : seq_cnt;
        dwell_load = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
    end

    simon_dwell_timer #(
        .W (DWELL_W)
    ) u_dwell (
        .clk      (pclk),
        .rst      (rst),
        .load     (state == DATA),
        .load_val (dwell_load),
        .dec      (state == SHOW),
        .zero     (tmr_zero)
    );

    // Playback FSM; stop overrides every state including a pending start.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            last_idx     <= '0;
            loop_q       <= 1'b0;
            dwell_q      <= '0;
            pattern_leds <= '0;
            cur_idx      <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state        <= IDLE;
                idx          <= '0;
                pattern_leds <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            idx <= '0;
                            if (seq_cnt == '0) begin
                                done <= 1'b1;
                            end else begin
                                last_idx <= ADDR_W'(cnt_clamp - (ADDR_W+1)'(1));
                                loop_q   <= loop;
                                dwell_q  <= dwell;
                                state    <= ADDR;
                            end
                        end
                    end
                    ADDR: state <= DATA;
                    DATA: begin
                        pattern_leds <= mem_rdata;
                        cur_idx      <= idx;
                        state        <= SHOW;
                    end
                    SHOW: begin
                        if (tmr_zero) begin
                            if ((idx != last_idx) || loop_q) begin
                                idx <= (idx != last_idx) ? idx + ADDR_W'(1) : '0;
`ifdef SIMON_SEQ_BLANK_EN
                                pattern_leds <= '0;
                                state        <= BLANK;
`else
                                state        <= ADDR;
`endif
                            end else begin
                                idx          <= '0;
                                pattern_leds <= '0;
                                done         <= 1'b1;
                                state        <= IDLE;
                            end
                        end
                    end
`ifdef SIMON_SEQ_BLANK_EN
                    BLANK: state <= ADDR;
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign mem_raddr = idx;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_simon_playback_seq.sv
// Self-checking bench for simon_playback_seq with a behavioural pattern memory
// and a per-cycle expected-output scoreboard.
module tb_simon_playback_seq;

    localparam int unsigned DW = 16;
    localparam int unsigned PW = 4;
    localparam int unsigned AW = 6;

    logic          pclk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          loop;
    logic [AW:0]   seq_cnt;
    logic [DW-1:0] dwell;
    logic [AW-1:0] mem_raddr;
    logic [PW-1:0] mem_rdata;
    logic [PW-1:0] pattern_leds;
    logic [AW-1:0] cur_idx;
    logic          busy;
    logic          done;

    typedef struct packed {
        logic [AW-1:0] raddr;
        logic [PW-1:0] leds;
        logic [AW-1:0] cur;
        logic          busy;
        logic          done;
    } obs_t;

    obs_t          exp_q[$];
    logic [PW-1:0] mem [64];
    int unsigned   n_assert = 0;
    int unsigned   n_fail   = 0;
    int unsigned   exp_cur  = 0;

    simon_playback_seq #(
        .DWELL_W (DW),
        .PAT_W   (PW),
        .ADDR_W  (AW)
    ) dut (
        .pclk         (pclk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .loop         (loop),
        .seq_cnt      (seq_cnt),
        .dwell        (dwell),
        .mem_raddr    (mem_raddr),
        .mem_rdata    (mem_rdata),
        .pattern_leds (pattern_leds),
        .cur_idx      (cur_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 pclk = ~pclk;

    // Synchronous-read pattern memory.
    always @(posedge pclk) mem_rdata <= mem[mem_raddr];

    function automatic obs_t mk(input int unsigned ra, input logic [PW-1:0] l,
                                input int unsigned c, input logic b, input logic d);
        obs_t o;
        o.raddr = AW'(ra);
        o.leds  = l;
        o.cur   = AW'(c);
        o.busy  = b;
        o.done  = d;
        return o;
    endfunction

    // Expected per-cycle outputs of a run started from IDLE, first entry = cycle after start edge.
    task automatic gen_run(input int unsigned cnt, input int unsigned dw, input bit lp,
                           input int unsigned n);
        obs_t          tmp[$];
        int unsigned   idx, last, d, cur;
        logic [PW-1:0] leds;
        bit            ended;
        idx   = 0;
        cur   = exp_cur;
        leds  = '0;
        ended = 0;
        last  = ((cnt > 64) ? 64 : cnt) - 1;
        d     = (dw == 0) ? 1 : dw;
        while (tmp.size() < n && !ended) begin
            tmp.push_back(mk(idx, leds, cur, 1'b1, 1'b0));
            tmp.push_back(mk(idx, leds, cur, 1'b1, 1'b0));
            leds = mem[idx];
            cur  = idx;
            for (int unsigned k = 0; k < d; k++) tmp.push_back(mk(idx, leds, cur, 1'b1, 1'b0));
            if (idx < last || lp) begin
                idx = (idx < last) ? idx + 1 : 0;
`ifdef SIMON_SEQ_BLANK_EN
                leds = '0;
                tmp.push_back(mk(idx, leds, cur, 1'b1, 1'b0));
`endif
            end else begin
                leds  = '0;
                tmp.push_back(mk(0, leds, cur, 1'b0, 1'b1));
                ended = 1;
            end
        end
        while (tmp.size() < n) tmp.push_back(mk(0, '0, cur, 1'b0, 1'b0));
        for (int unsigned i = 0; i < n; i++) exp_q.push_back(tmp[i]);
        exp_cur = tmp[n-1].cur;
    endtask

    // Advance n cycles, comparing outputs #1 after each edge against the scoreboard.
    task automatic run(input int unsigned n, input bit noise, input string tag);
        obs_t o, e;
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
            start = 1'b0;
            stop  = 1'b0;
            o = {mem_raddr, pattern_leds, cur_idx, busy, done};
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL %s scoreboard empty observed=%h", tag, o);
                e = '0;
            end else begin
                e = exp_q.pop_front();
                assert (o === e) else begin
                    n_fail++;
                    $error("FAIL %s cycle %0d observed raddr=%0d leds=%b cur=%0d busy=%b done=%b expected raddr=%0d leds=%b cur=%0d busy=%b done=%b",
                           tag, i, o.raddr, o.leds, o.cur, o.busy, o.done,
                           e.raddr, e.leds, e.cur, e.busy, e.done);
                end
            end
            // While busy, a new start and changed run parameters must be ignored.
            if (noise && e.busy) begin
                start   = 1'($urandom_range(0, 1));
                seq_cnt = (AW+1)'($urandom);
                dwell   = DW'($urandom_range(0, 9));
                loop    = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic set_run(input int unsigned cnt, input int unsigned dw, input bit lp);
        seq_cnt = (AW+1)'(cnt);
        dwell   = DW'(dw);
        loop    = lp;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        set_run(0, 0, 1'b0);
        for (int i = 0; i < 64; i++) mem[i] = PW'($urandom);

        // Reset state
        exp_q.push_back(mk(0, '0, 0, 1'b0, 1'b0));
        exp_q.push_back(mk(0, '0, 0, 1'b0, 1'b0));
        run(2, 1'b0, "reset");
        rst = 1'b0;
        exp_cur = 0;

        // Once-run with start/parameter noise while busy
        mem[0] = 4'b0001;
        mem[1] = 4'b1000;
        set_run(2, 3, 1'b0);
        gen_run(2, 3, 1'b0, 14);
        start = 1'b1;
        run(14, 1'b1, "once_run");

        // Loop-run, done never asserts, then stop
        set_run(2, 3, 1'b1);
        gen_run(2, 3, 1'b1, 20);
        start = 1'b1;
        run(20, 1'b0, "loop_run");
        exp_q.push_back(mk(0, '0, exp_cur, 1'b0, 1'b0));
        stop = 1'b1;
        run(1, 1'b0, "loop_stop");

        // Stop during the second SHOW of a loop-run
        gen_run(2, 3, 1'b1, 8);
        start = 1'b1;
        run(8, 1'b0, "loop_run2");
        exp_q.push_back(mk(0, '0, exp_cur, 1'b0, 1'b0));
        stop = 1'b1;
        run(1, 1'b0, "stop_show2");

        // Simultaneous start+stop from IDLE
        exp_q.push_back(mk(0, '0, exp_cur, 1'b0, 1'b0));
        exp_q.push_back(mk(0, '0, exp_cur, 1'b0, 1'b0));
        start = 1'b1;
        stop  = 1'b1;
        run(2, 1'b0, "start_stop");

        // Empty sequence
        set_run(0, 3, 1'b0);
        exp_q.push_back(mk(0, '0, exp_cur, 1'b0, 1'b1));
        exp_q.push_back(mk(0, '0, exp_cur, 1'b0, 1'b0));
        exp_q.push_back(mk(0, '0, exp_cur, 1'b0, 1'b0));
        start = 1'b1;
        run(3, 1'b0, "seq_cnt0");

        // Zero dwell shows each pattern one cycle
        set_run(2, 0, 1'b0);
        gen_run(2, 0, 1'b0, 10);
        start = 1'b1;
        run(10, 1'b0, "dwell0");

        // Reset during DATA, then restart from index 0
        mem[0] = 4'b0110;
        mem[1] = 4'b1011;
        set_run(2, 2, 1'b1);
        gen_run(2, 2, 1'b1, 2);
        start = 1'b1;
        run(2, 1'b0, "pre_reset");
        rst = 1'b1;
        exp_q.push_back(mk(0, '0, 0, 1'b0, 1'b0));
        run(1, 1'b0, "rst_data");
        rst = 1'b0;
        exp_cur = 0;
        set_run(2, 2, 1'b0);
        gen_run(2, 2, 1'b0, 10);
        start = 1'b1;
        run(10, 1'b0, "restart");

        // Full 64-entry loop wraps from 63 back to 0
        for (int i = 0; i < 64; i++) mem[i] = PW'($urandom);
        set_run(64, 1, 1'b1);
`ifdef SIMON_SEQ_BLANK_EN
        gen_run(64, 1, 1'b1, 64 * 4 + 8);
        start = 1'b1;
        run(64 * 4 + 8, 1'b0, "full_wrap");
`else
        gen_run(64, 1, 1'b1, 64 * 3 + 6);
        start = 1'b1;
        run(64 * 3 + 6, 1'b0, "full_wrap");
`endif
        exp_q.push_back(mk(0, '0, exp_cur, 1'b0, 1'b0));
        stop = 1'b1;
        run(1, 1'b0, "full_stop");

`ifdef SIMON_SEQ_BLANK_EN
        // Identical neighbours separated by a blank cycle
        mem[0] = 4'b0101;
        mem[1] = 4'b0101;
        set_run(2, 2, 1'b1);
        gen_run(2, 2, 1'b1, 16);
        start = 1'b1;
        run(16, 1'b0, "blank_sep");
        exp_q.push_back(mk(0, '0, exp_cur, 1'b0, 1'b0));
        stop = 1'b1;
        run(1, 1'b0, "blank_stop");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
